// File: rtl/fp_round_pack.sv
// Rounds a normalised extended-precision result (hidden|frac|G|R|S) and packs it
// into an IEEE-754 binary word; two-stage valid/ready pipeline with status flags.
module fp_round_pack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic                   In_Sign,
  input  logic [EXP_W+1:0]       In_Exp,
  input  logic [MAN_W+3:0]       In_Man,
  input  logic [1:0]             In_Class,
  input  logic [1:0]             Round_Mode,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [EXP_W+MAN_W:0]   Out_FP,
  output logic [2:0]             Out_Flags
);

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  localparam logic [1:0] RM_RNE  = 2'b00;
  localparam logic [1:0] RM_RTZ  = 2'b01;
  localparam logic [1:0] RM_PINF = 2'b10;
  localparam logic [1:0] RM_MINF = 2'b11;

  localparam logic signed [EXP_W+2:0] EXP_MAX = (EXP_W+3)'((1 << EXP_W) - 1);

  // stage 1 state
  logic                   s1_valid;
  logic                   s1_sign;
  logic [EXP_W+1:0]       s1_exp;
  logic [MAN_W+1:0]       s1_sum;
  logic [1:0]             s1_class;
  logic [1:0]             s1_mode;
  logic                   s1_inexact;

  // stage 2 state
  logic                   s2_valid;
  logic                   s2_advance;

  assign s2_advance = !s2_valid | Out_Ready;
  assign In_Ready   = !s1_valid | s2_advance;
  assign Out_Valid  = s2_valid;

  // ---------------- stage 1: rounding increment ----------------
  logic             lsb, g, r, st, any_lost, inc;
  logic [MAN_W+1:0] sum_d;

  assign lsb      = In_Man[3];
  assign g        = In_Man[2];
  assign r        = In_Man[1];
  assign st       = In_Man[0];
  assign any_lost = g | r | st;

  always_comb begin
    inc = 1'b0;
    case (Round_Mode)
      RM_RNE:  inc = g & (r | st | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_PINF: inc = any_lost & !In_Sign;
      RM_MINF: inc = any_lost & In_Sign;
      default: inc = 1'b0;
    endcase
  end

  assign sum_d = {1'b0, In_Man[MAN_W+3:3]} + (MAN_W+2)'(inc);

  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (In_Ready) s1_valid <= In_Valid;
  end

  always_ff @(posedge clk) begin
    if (In_Ready && In_Valid) begin
      s1_sign    <= In_Sign;
      s1_exp     <= In_Exp;
      s1_sum     <= sum_d;
      s1_class   <= In_Class;
      s1_mode    <= Round_Mode;
      s1_inexact <= any_lost;
    end
  end

  // ---------------- stage 2: renormalise, range check, pack ----------------
  logic                    carry;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+2:0] exp_f;
  logic [EXP_W+MAN_W:0]    fp_d, inf_w, max_w, nan_w;
  logic [2:0]              flags_d;
  logic                    ovf_to_inf;

  assign carry = s1_sum[MAN_W+1];
  assign frac  = carry ? '0 : s1_sum[MAN_W-1:0];
  // one extra bit of headroom so exp+1 on carry can never wrap
  assign exp_f = {s1_exp[EXP_W+1], s1_exp} + {{(EXP_W+2){1'b0}}, carry};

  assign inf_w = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_w = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  assign nan_w = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  always_comb begin
    ovf_to_inf = 1'b1;
    case (s1_mode)
      RM_RNE:  ovf_to_inf = 1'b1;
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_PINF: ovf_to_inf = !s1_sign;
      RM_MINF: ovf_to_inf = s1_sign;
      default: ovf_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    fp_d    = {s1_sign, exp_f[EXP_W-1:0], frac};
    flags_d = {2'b00, s1_inexact};
    case (s1_class)
      CLS_NAN: begin
        fp_d    = nan_w;
        flags_d = 3'b000;
      end
      CLS_INF: begin
        fp_d    = inf_w;
        flags_d = 3'b000;
      end
      CLS_ZERO: begin
        fp_d    = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
        flags_d = 3'b000;
      end
      CLS_NORM: begin
        if (exp_f <= 0) begin
          fp_d    = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
          flags_d = 3'b011;
        end else if (exp_f >= EXP_MAX) begin
          fp_d    = ovf_to_inf ? inf_w : max_w;
          flags_d = 3'b101;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      Out_FP    <= '0;
      Out_Flags <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Out_FP    <= fp_d;
        Out_Flags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack (FP16 defaults): rounding modes, range/class
// handling, latency, backpressure ordering and mid-flight reset.
module tb_fp_round_pack;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, PINF = 2'b10, MINF = 2'b11;
  localparam logic [1:0] NRM = 2'b00, ZER = 2'b01, INF = 2'b10, NAN = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, in_ready, in_sign;
  logic [EXP_W+1:0]     in_exp;
  logic [MAN_W+3:0]     in_man;
  logic [1:0]           in_class, round_mode;
  logic                 out_valid, out_ready;
  logic [EXP_W+MAN_W:0] out_fp;
  logic [2:0]           out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .In_Sign(in_sign), .In_Exp(in_exp), .In_Man(in_man),
    .In_Class(in_class), .Round_Mode(round_mode),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_FP(out_fp), .Out_Flags(out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic s, input int e, input logic [MAN_W-1:0] frac,
                       input logic [2:0] grs, input logic [1:0] cls, input logic [1:0] mode);
    in_sign    = s;
    in_exp     = e[EXP_W+1:0];
    in_man     = {1'b1, frac, grs};
    in_class   = cls;
    round_mode = mode;
  endtask

  // one beat, no backpressure: output must be absent one cycle later, present two later
  task automatic send(input string tag, input logic s, input int e, input logic [MAN_W-1:0] frac,
                      input logic [2:0] grs, input logic [1:0] cls, input logic [1:0] mode,
                      input logic [15:0] efp, input logic [2:0] efl);
    @(negedge clk);
    out_ready = 1'b1;
    drive(s, e, frac, grs, cls, mode);
    in_valid = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_fp"}, out_fp, efp);
    chk({tag, "_flg"}, out_flags, efl);
  endtask

  logic [15:0] bp_exp [4];
  int snd, rcv, cyc;
  logic fire_in, fire_out;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, '0, 3'b000, NRM, RNE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_fp", out_fp, 0);
    chk("rst_flg", out_flags, 0);
    chk("rst_rdy", in_ready, 1);

    // rounding
    send("pass",     0, 15, 10'h000, 3'b000, NRM, RNE,  16'h3C00, 3'b000);
    send("carry",    0, 15, 10'h3FF, 3'b100, NRM, RNE,  16'h4000, 3'b001);
    send("tie_even", 0, 15, 10'h000, 3'b100, NRM, RNE,  16'h3C00, 3'b001);
    send("tie_odd",  0, 15, 10'h001, 3'b100, NRM, RNE,  16'h3C02, 3'b001);
    send("rtz",      0, 15, 10'h3FF, 3'b100, NRM, RTZ,  16'h3FFF, 3'b001);
    send("pinf_pos", 0, 15, 10'h000, 3'b001, NRM, PINF, 16'h3C01, 3'b001);
    send("pinf_neg", 1, 15, 10'h000, 3'b001, NRM, PINF, 16'hBC00, 3'b001);
    send("minf_neg", 1, 15, 10'h000, 3'b010, NRM, MINF, 16'hBC01, 3'b001);
    // overflow / range
    send("ovf_rne",  0, 30, 10'h3FF, 3'b100, NRM, RNE,  16'h7C00, 3'b101);
    send("max_rtz",  0, 30, 10'h3FF, 3'b100, NRM, RTZ,  16'h7BFF, 3'b001);
    send("max_pneg", 1, 30, 10'h3FF, 3'b100, NRM, PINF, 16'hFBFF, 3'b001);
    send("ovf_ppos", 0, 30, 10'h3FF, 3'b001, NRM, PINF, 16'h7C00, 3'b101);
    send("ovf_pneg", 1, 40, 10'h000, 3'b000, NRM, PINF, 16'hFBFF, 3'b101);
    send("ovf_mpos", 0, 63, 10'h000, 3'b000, NRM, MINF, 16'h7BFF, 3'b101);
    send("ovf_mneg", 1, 31, 10'h000, 3'b000, NRM, MINF, 16'hFC00, 3'b101);
    send("ovf_rtz",  0, 31, 10'h000, 3'b000, NRM, RTZ,  16'h7BFF, 3'b101);
    send("max_norm", 0, 30, 10'h3FF, 3'b000, NRM, RNE,  16'h7BFF, 3'b000);
    send("min_norm", 0, 1,  10'h000, 3'b000, NRM, RNE,  16'h0400, 3'b000);
    send("udf_neg3", 1, -3, 10'h000, 3'b000, NRM, RNE,  16'h8000, 3'b011);
    send("udf_zero", 0, 0,  10'h005, 3'b000, NRM, RNE,  16'h0000, 3'b011);
    send("udf_deep", 0, -64,10'h3FF, 3'b111, NRM, PINF, 16'h0000, 3'b011);
    // classes
    send("nan",      1, 7,  10'h123, 3'b111, NAN, RNE,  16'h7E00, 3'b000);
    send("inf",      1, 7,  10'h123, 3'b111, INF, RNE,  16'hFC00, 3'b000);
    send("zero",     1, 7,  10'h123, 3'b111, ZER, RNE,  16'h8000, 3'b000);

    // backpressure: 4 beats, Out_Ready low for 3 cycles
    for (int i = 0; i < 4; i++) bp_exp[i] = 16'h3C01 + 16'(i);
    snd = 0; rcv = 0; cyc = 0;
    while (rcv < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (snd < 4);
      drive(1'b0, 15, 10'(snd + 1), 3'b000, NRM, RNE);
      #1;
      if (cyc == 2) chk("bp_rdy_low", in_ready, 0);
      if (out_valid && !out_ready) begin
        chk("bp_stall_fp", out_fp, bp_exp[rcv]);
        chk("bp_stall_flg", out_flags, 0);
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) chk("bp_order", out_fp, bp_exp[rcv]);
      @(posedge clk);
      if (fire_in) snd++;
      if (fire_out) rcv++;
      cyc++;
    end
    chk("bp_count", rcv, 4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_dup", out_valid, 0);
    end

    // reset with two beats in flight
    @(negedge clk);
    drive(1'b0, 15, 10'h011, 3'b000, NRM, RNE);
    in_valid = 1'b1;
    @(negedge clk);
    drive(1'b0, 15, 10'h022, 3'b000, NRM, RNE);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_vld", out_valid, 0);
    chk("rst2_rdy", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst2_drop", out_valid, 0);
    end
    send("post_rst", 0, 16, 10'h200, 3'b000, NRM, RNE, 16'h4200, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
